// File: rtl/control_v2_pkg.sv
// Shared definitions for the control_v2 AXI4-Lite register block.
package control_v2_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int unsigned REG_BYTES  = 4;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT_W,
        WR_WAIT_AW,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    function automatic logic [1:0] resp_for(input logic hit);
        return hit ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/control_v2_regfile.sv
// NUM_REGS x 32-bit register storage with byte-strobed write port and
// a one-cycle pulse per register on the cycle after it is written.
module control_v2_regfile
    import control_v2_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [REG_BYTES-1:0]     wr_strb,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [31:0]              rd_data,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    logic [NUM_REGS-1:0][31:0] regs;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs     <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (wr_en) begin
                // An all-zero strobe still counts as a commit and pulses.
                wr_pulse[wr_idx] <= 1'b1;
                for (int b = 0; b < REG_BYTES; b++) begin
                    if (wr_strb[b]) begin
                        regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign rd_data = regs[rd_idx];
    assign reg_q   = regs;

endmodule

// File: rtl/control_v2_axil_slave.sv
// AXI4-Lite responder for the control_v2 register bank: independent write
// and read FSMs with registered handshake outputs in front of control_v2_regfile.
module control_v2_axil_slave
    import control_v2_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [ADDR_WIDTH-1:0]        AWADDR,
    input  logic [2:0]                   AWPROT,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [DATA_WIDTH-1:0]        WDATA,
    input  logic [DATA_WIDTH/8-1:0]      WSTRB,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [ADDR_WIDTH-1:0]        ARADDR,
    input  logic [2:0]                   ARPROT,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [DATA_WIDTH-1:0]        RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]          reg_wr_pulse
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_SPAN = ADDR_WIDTH'(NUM_REGS * REG_BYTES);

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [DATA_WIDTH/8-1:0] w_strb_q;

    logic                    aw_hs, w_hs, ar_hs;
    logic                    commit, wr_hit, rd_hit;
    logic [ADDR_WIDTH-1:0]   commit_addr;
    logic [DATA_WIDTH-1:0]   commit_data;
    logic [DATA_WIDTH/8-1:0] commit_strb;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    unused_bits;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // The second of AW/W completes the write; take whichever half arrives
    // live this cycle and the other from its holding register.
    always_comb begin
        commit = 1'b0;
        unique case (wr_state)
            WR_IDLE:    commit = aw_hs && w_hs;
            WR_WAIT_W:  commit = w_hs;
            WR_WAIT_AW: commit = aw_hs;
            WR_RESP:    commit = 1'b0;
        endcase
        commit_addr = (wr_state == WR_WAIT_W)  ? aw_addr_q : AWADDR;
        commit_data = (wr_state == WR_WAIT_AW) ? w_data_q  : WDATA;
        commit_strb = (wr_state == WR_WAIT_AW) ? w_strb_q  : WSTRB;
    end

    assign wr_hit = commit_addr < ADDR_SPAN;
    assign rd_hit = ARADDR < ADDR_SPAN;

    control_v2_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk      (ACLK),
        .rst      (ARESET),
        .wr_en    (commit && wr_hit),
        .wr_idx   (commit_addr[2 +: IDX_W]),
        .wr_data  (commit_data),
        .wr_strb  (commit_strb),
        .rd_idx   (ARADDR[2 +: IDX_W]),
        .rd_data  (rd_data),
        .reg_q    (reg_q),
        .wr_pulse (reg_wr_pulse)
    );

    // Readies are registered so they stay low through reset and rise one
    // cycle after ARESET drops.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state  <= WR_IDLE;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            unique case (wr_state)
                WR_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state <= WR_RESP;
                        AWREADY  <= 1'b0;
                        WREADY   <= 1'b0;
                        BVALID   <= 1'b1;
                        BRESP    <= resp_for(wr_hit);
                    end else if (aw_hs) begin
                        wr_state  <= WR_WAIT_W;
                        AWREADY   <= 1'b0;
                        WREADY    <= 1'b1;
                        aw_addr_q <= AWADDR;
                    end else if (w_hs) begin
                        wr_state <= WR_WAIT_AW;
                        AWREADY  <= 1'b1;
                        WREADY   <= 1'b0;
                        w_data_q <= WDATA;
                        w_strb_q <= WSTRB;
                    end else begin
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                    end
                end
                WR_WAIT_W: begin
                    if (w_hs) begin
                        wr_state <= WR_RESP;
                        WREADY   <= 1'b0;
                        BVALID   <= 1'b1;
                        BRESP    <= resp_for(wr_hit);
                    end
                end
                WR_WAIT_AW: begin
                    if (aw_hs) begin
                        wr_state <= WR_RESP;
                        AWREADY  <= 1'b0;
                        BVALID   <= 1'b1;
                        BRESP    <= resp_for(wr_hit);
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        wr_state <= WR_IDLE;
                        BVALID   <= 1'b0;
                        AWREADY  <= 1'b1;
                        WREADY   <= 1'b1;
                    end
                end
            endcase
        end
    end

    // RDATA is captured from the pre-edge register contents, so a same-edge
    // write commit is not visible to the read.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state <= RD_IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
        end else begin
            unique case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state <= RD_DATA;
                        ARREADY  <= 1'b0;
                        RVALID   <= 1'b1;
                        RDATA    <= rd_hit ? rd_data : '0;
                        RRESP    <= resp_for(rd_hit);
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (RREADY) begin
                        rd_state <= RD_IDLE;
                        RVALID   <= 1'b0;
                        ARREADY  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign unused_bits = ^{AWPROT, ARPROT};

endmodule
